// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: bundles the receiver's line-side inputs and result outputs.
//   i_CLK_ENABLE     oversample tick, one i_CLK cycle wide
//   i_RX             asynchronous serial line, idles high
//   o_DATA           last received word
//   o_RX_DONE        one-cycle pulse per completed frame
//   o_FRAMING_ERROR  stop-bit error of the last frame
//   o_PARITY_ERROR   parity error of the last frame
//   o_BUSY           receiver is not idle
// master: the side that drives the line and tick (e.g. a testbench or host).
// slave:  the receiver itself.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 i_CLK_ENABLE;
  logic                 i_RX;
  logic [DATA_BITS-1:0] o_DATA;
  logic                 o_RX_DONE;
  logic                 o_FRAMING_ERROR;
  logic                 o_PARITY_ERROR;
  logic                 o_BUSY;

  modport master (
    output i_CLK_ENABLE, i_RX,
    input  o_DATA, o_RX_DONE, o_FRAMING_ERROR, o_PARITY_ERROR, o_BUSY
  );

  modport slave (
    input  i_CLK_ENABLE, i_RX,
    output o_DATA, o_RX_DONE, o_FRAMING_ERROR, o_PARITY_ERROR, o_BUSY
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with configurable data bits,
// parity and stop bits.
//   i_CLK    single clock, rising edge
//   i_RESET  synchronous active-high reset, overrides the tick
//   bus      uart_rx_param_if.slave (tick, line in, data/flags/busy out)
// Each bit is OVERSAMPLE ticks long; the value is the majority of three samples
// taken at the end of each bit period, which lands on mid-bit because START
// only waits half a bit before handing over to DATA.
module uart_rx_param #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input logic           i_CLK,
  input logic           i_RESET,
  uart_rx_param_if.slave bus
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);

  localparam logic [TickW-1:0] TickHalf = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickS1   = TickW'(OVERSAMPLE - 3);
  localparam logic [TickW-1:0] TickS2   = TickW'(OVERSAMPLE - 2);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);
  localparam logic             HasParity = (PARITY_MODE != 0);
  localparam logic             OddParity = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitIdle
  } state_e;

  state_e               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [TickW-1:0]     tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 samp_a;
  logic                 samp_b;
  logic                 par_bit;
  logic                 stop_err;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 ferr_q;
  logic                 perr_q;
  logic                 busy_q;

  logic bit_val;
  logic par_err;

  // Third sample is the live rx_s on the final tick of the bit.
  assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign par_err = HasParity & ((^shift_reg ^ par_bit) != OddParity);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state     <= StIdle;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      par_bit   <= 1'b0;
      stop_err  <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_meta <= bus.i_RX;
      rx_s    <= rx_meta;
      done_q  <= 1'b0;

      if (bus.i_CLK_ENABLE) begin
        case (state)
          StIdle: begin
            if (!rx_s) begin
              state    <= StStart;
              tick_cnt <= '0;
              busy_q   <= 1'b1;
            end
          end

          StStart: begin
            if (tick_cnt == TickHalf) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (rx_s) begin
                // Line went back high before mid start bit: treat as a glitch.
                state  <= StIdle;
                busy_q <= 1'b0;
              end else begin
                state <= StData;
              end
            end else begin
              tick_cnt <= tick_cnt + TickW'(1);
            end
          end

          StData, StParity, StStop: begin
            if (tick_cnt == TickS1) samp_a <= rx_s;
            if (tick_cnt == TickS2) samp_b <= rx_s;

            if (tick_cnt != TickLast) begin
              tick_cnt <= tick_cnt + TickW'(1);
            end else begin
              tick_cnt <= '0;
              if (state == StData) begin
                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                if (bit_cnt == DataLast) begin
                  bit_cnt  <= '0;
                  stop_err <= 1'b0;
                  state    <= HasParity ? StParity : StStop;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end else if (state == StParity) begin
                par_bit <= bit_val;
                bit_cnt <= '0;
                state   <= StStop;
              end else if (bit_cnt != StopLast) begin
                stop_err <= stop_err | ~bit_val;
                bit_cnt  <= bit_cnt + 4'd1;
              end else begin
                data_q <= shift_reg;
                ferr_q <= stop_err | ~bit_val;
                perr_q <= par_err;
                done_q <= 1'b1;
                // A low final stop bit means break/framing error: wait for the
                // line to recover so a held-low line cannot retrigger frames.
                if (bit_val) begin
                  state  <= StIdle;
                  busy_q <= 1'b0;
                end else begin
                  state <= StWaitIdle;
                end
              end
            end
          end

          StWaitIdle: begin
            if (rx_s) begin
              state  <= StIdle;
              busy_q <= 1'b0;
            end
          end

          default: begin
            state  <= StIdle;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_DATA          = data_q;
  assign bus.o_RX_DONE       = done_q;
  assign bus.o_FRAMING_ERROR = ferr_q;
  assign bus.o_PARITY_ERROR  = perr_q;
  assign bus.o_BUSY          = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8 data bits, even parity, 1 stop bit,
// 16x oversampling. Line is driven one bit period (16 ticks) at a time.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   en_div  = 1;
  logic en_hold = 1'b0;
  int   errors  = 0;
  int   checks  = 0;
  int   done_cnt = 0;
  int   base;

  uart_rx_param_if #(.DATA_BITS(8)) ifc ();

  uart_rx_param #(
    .DATA_BITS  (8),
    .PARITY_MODE(1),
    .STOP_BITS  (1),
    .OVERSAMPLE (16)
  ) dut (
    .i_CLK  (clk),
    .i_RESET(rst),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  // Tick generator: one enable every en_div clocks, suppressed while en_hold.
  initial begin
    int en_cnt;
    en_cnt = 0;
    ifc.i_CLK_ENABLE = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      en_cnt = (en_cnt + 1) % en_div;
      ifc.i_CLK_ENABLE = !en_hold && (en_cnt == 0);
    end
  end

  always @(negedge clk) begin
    if (ifc.o_RX_DONE === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ifc.i_RX = b;
    clks(16 * en_div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stp);
  endtask

  initial begin
    logic [7:0] fz;
    ifc.i_RX = 1'b1;

    // Reset state
    clks(3);
    chk("rst_data", 32'(ifc.o_DATA), 32'h00);
    chk("rst_done", 32'(ifc.o_RX_DONE), 32'd0);
    chk("rst_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("rst_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("rst_busy", 32'(ifc.o_BUSY), 32'd0);
    rst = 1'b0;
    clks(5);

    // Good frame 0xA5, even parity bit 0
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("a5_done", 32'(done_cnt - base), 32'd1);
    chk("a5_data", 32'(ifc.o_DATA), 32'hA5);
    chk("a5_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("a5_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("a5_busy", 32'(ifc.o_BUSY), 32'd0);

    // Wrong parity
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("par_done", 32'(done_cnt - base), 32'd1);
    chk("par_data", 32'(ifc.o_DATA), 32'hA5);
    chk("par_perr", 32'(ifc.o_PARITY_ERROR), 32'd1);
    chk("par_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);

    // Break: 0x00, stop low, line held low for 40 bit times
    base = done_cnt;
    send_frame(8'h00, 1'b0, 1'b0);
    clks(40 * 16);
    chk("brk_done", 32'(done_cnt - base), 32'd1);
    chk("brk_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd1);
    chk("brk_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("brk_data", 32'(ifc.o_DATA), 32'h00);
    chk("brk_busy_wait", 32'(ifc.o_BUSY), 32'd1);
    ifc.i_RX = 1'b1;
    clks(32);
    chk("brk_busy_idle", 32'(ifc.o_BUSY), 32'd0);
    chk("brk_done_after", 32'(done_cnt - base), 32'd1);

    // 4-tick low glitch on an idle line
    base = done_cnt;
    ifc.i_RX = 1'b0;
    clks(4);
    ifc.i_RX = 1'b1;
    clks(1);
    chk("gl_busy_start", 32'(ifc.o_BUSY), 32'd1);
    clks(40);
    chk("gl_busy_end", 32'(ifc.o_BUSY), 32'd0);
    chk("gl_done", 32'(done_cnt - base), 32'd0);
    chk("gl_data", 32'(ifc.o_DATA), 32'h00);
    chk("gl_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd1);
    chk("gl_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);

    // Reset after 3rd data bit, then frame 0x3C
    base = done_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ifc.i_RX = 1'b1;
    rst = 1'b1;
    clks(1);
    rst = 1'b0;
    chk("mrst_data", 32'(ifc.o_DATA), 32'h00);
    chk("mrst_done", 32'(ifc.o_RX_DONE), 32'd0);
    chk("mrst_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("mrst_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("mrst_busy", 32'(ifc.o_BUSY), 32'd0);
    clks(32);
    chk("mrst_nodone", 32'(done_cnt - base), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("3c_done", 32'(done_cnt - base), 32'd1);
    chk("3c_data", 32'(ifc.o_DATA), 32'h3C);
    chk("3c_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("3c_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);

    // Tick at 1 in 4 cycles, bit timing scaled
    en_div = 4;
    clks(8);
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("slow_done", 32'(done_cnt - base), 32'd1);
    chk("slow_data", 32'(ifc.o_DATA), 32'hA5);
    chk("slow_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("slow_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("slow_busy", 32'(ifc.o_BUSY), 32'd0);

    // Freeze the tick mid bit 4 of frame 0xC3; line timing paused with it
    fz = 8'hC3;
    base = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(fz[i]);
    ifc.i_RX = fz[4];
    clks(32);
    en_hold = 1'b1;
    clks(8);
    chk("frz_busy_a", 32'(ifc.o_BUSY), 32'd1);
    clks(300);
    chk("frz_busy_b", 32'(ifc.o_BUSY), 32'd1);
    chk("frz_nodone", 32'(done_cnt - base), 32'd0);
    chk("frz_data_hold", 32'(ifc.o_DATA), 32'hA5);
    en_hold = 1'b0;
    clks(32);
    for (int i = 5; i < 8; i++) send_bit(fz[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("frz_done", 32'(done_cnt - base), 32'd1);
    chk("frz_data", 32'(ifc.o_DATA), 32'hC3);
    chk("frz_ferr", 32'(ifc.o_FRAMING_ERROR), 32'd0);
    chk("frz_perr", 32'(ifc.o_PARITY_ERROR), 32'd0);
    chk("frz_busy_end", 32'(ifc.o_BUSY), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
